// File: rtl/ram64_pkg.sv
// Shared constants for the 64-word Hack data memory: word width, address
// width and the bank/word select bit ranges of the address.
package ram64_pkg;
    localparam int WORD_W        = 16;
    localparam int RAM64_ADDR_W  = 6;
    localparam int RAM8_ADDR_W   = 3;
    localparam int NUM_BANKS     = 8;
    localparam int BANK_SEL_HI   = 5;
    localparam int BANK_SEL_LO   = 3;
    localparam int WORD_SEL_HI   = 2;
    localparam int WORD_SEL_LO   = 0;
endpackage

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer: routes a single input bit to the output selected by sel.
module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic [7:0] out
);
    // one-hot steering of in onto the selected lane
    always_comb begin
        out = 8'b0000_0000;
        case (sel)
            3'd0:    out[0] = in;
            3'd1:    out[1] = in;
            3'd2:    out[2] = in;
            3'd3:    out[3] = in;
            3'd4:    out[4] = in;
            3'd5:    out[5] = in;
            3'd6:    out[6] = in;
            3'd7:    out[7] = in;
            default: out = 8'b0000_0000;
        endcase
    end
endmodule

// File: rtl/mux8way16.sv
// 8-way WIDTH-bit multiplexer selecting one of a..h by sel.
module mux8way16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] out
);
    // select the addressed input word
    always_comb begin
        out = '0;
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            3'd7:    out = h;
            default: out = '0;
        endcase
    end
endmodule

// File: rtl/ram8.sv
// 8-word bank: async-clear registers, demuxed load, combinational read.
module ram8
    import ram64_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in,
    input  logic                   load,
    input  logic [RAM8_ADDR_W-1:0] address,
    output logic [WIDTH-1:0]       out
);
    logic [7:0]       load_s;
    logic [WIDTH-1:0] mem_r [0:7];

    dmux8way u_dmux (
        .in  (load),
        .sel (address),
        .out (load_s)
    );

    // word storage; reset clears immediately and blocks any write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load_s[i]) begin
                    mem_r[i] <= in;
                end
            end
        end
    end

    mux8way16 #(.WIDTH(WIDTH)) u_mux (
        .a   (mem_r[0]),
        .b   (mem_r[1]),
        .c   (mem_r[2]),
        .d   (mem_r[3]),
        .e   (mem_r[4]),
        .f   (mem_r[5]),
        .g   (mem_r[6]),
        .h   (mem_r[7]),
        .sel (address),
        .out (out)
    );
endmodule

// File: rtl/ram64.sv
// 64-word Hack data memory: eight ram8 banks, bank chosen by address[5:3].
module ram64
    import ram64_pkg::*;
#(
    parameter int WIDTH      = WORD_W,
    parameter int DEPTH_LOG2 = RAM64_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      in,
    input  logic                  load,
    input  logic [DEPTH_LOG2-1:0] address,
    output logic [WIDTH-1:0]      out
);
    logic [2:0]       bank_sel_s;
    logic [2:0]       word_sel_s;
    logic [7:0]       bank_load_s;
    logic [WIDTH-1:0] bank_out_s [0:NUM_BANKS-1];

    assign bank_sel_s = address[BANK_SEL_HI:BANK_SEL_LO];
    assign word_sel_s = address[WORD_SEL_HI:WORD_SEL_LO];

    dmux8way u_bank_dmux (
        .in  (load),
        .sel (bank_sel_s),
        .out (bank_load_s)
    );

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram8 #(.WIDTH(WIDTH)) u_ram8 (
            .clk     (clk),
            .reset   (reset),
            .in      (in),
            .load    (bank_load_s[b]),
            .address (word_sel_s),
            .out     (bank_out_s[b])
        );
    end

    mux8way16 #(.WIDTH(WIDTH)) u_bank_mux (
        .a   (bank_out_s[0]),
        .b   (bank_out_s[1]),
        .c   (bank_out_s[2]),
        .d   (bank_out_s[3]),
        .e   (bank_out_s[4]),
        .f   (bank_out_s[5]),
        .g   (bank_out_s[6]),
        .h   (bank_out_s[7]),
        .sel (bank_sel_s),
        .out (out)
    );
endmodule

// File: tb/tb_ram64.sv
// Self-checking bench for ram64 against a plain array model of the memory.
module tb_ram64;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [5:0]  address;
    logic [15:0] out;

    logic [15:0] model [0:63];
    int total = 0;
    int bad   = 0;

    ram64 dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .load    (load),
        .address (address),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 16'h0000;
    endtask

    task automatic write_word(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        in      = d;
        load    = 1'b1;
        @(posedge clk);
        model[a] = d;
        #1;
        load = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 64; i++) begin
            address = 6'(i);
            #1;
            check(tag, out, model[i]);
        end
    endtask

    task automatic read_at(input string tag, input logic [5:0] a);
        address = a;
        #1;
        check(tag, out, model[a]);
    endtask

    initial begin
        reset   = 1'b1;
        in      = 16'h0000;
        load    = 1'b0;
        address = 6'd0;
        clear_model();
        #10;
        reset = 1'b0;
        sweep("reset_sweep");

        // directed write/read at the address boundaries
        write_word(6'd0, 16'h1234);
        write_word(6'd63, 16'hBEEF);
        read_at("rd_addr0", 6'd0);
        read_at("rd_addr63", 6'd63);
        read_at("rd_addr7", 6'd7);
        read_at("rd_addr8", 6'd8);
        read_at("rd_addr56", 6'd56);
        check("addr0_const", model[0], 16'h1234);

        // bank isolation
        for (int k = 0; k < 8; k++) write_word(6'(8 * k + 3), 16'h00A0 + 16'(k));
        sweep("bank_iso");
        address = 6'd43;
        #1;
        check("bank5_word3", out, 16'h00A5);

        // read-during-write
        write_word(6'd21, 16'h5555);
        @(negedge clk);
        address = 6'd21;
        in      = 16'hAAAA;
        load    = 1'b1;
        #1;
        check("rdw_before", out, 16'h5555);
        @(posedge clk);
        model[21] = 16'hAAAA;
        #1;
        check("rdw_after", out, 16'hAAAA);
        load = 1'b0;

        // load=0 hold
        in = 16'hFFFF;
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            check("hold", out, 16'hAAAA);
        end

        // randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  a;
            logic [15:0] d;
            logic        w;
            a = 6'($urandom_range(0, 63));
            d = 16'($urandom);
            w = 1'($urandom_range(0, 1));
            @(negedge clk);
            address = a;
            in      = d;
            load    = w;
            #1;
            check("rnd_pre", out, model[a]);
            @(posedge clk);
            if (w) model[a] = d;
            #1;
            check("rnd_post", out, model[a]);
        end
        load = 1'b0;
        sweep("rnd_sweep");

        // async reset mid-cycle
        @(negedge clk);
        address = 6'd21;
        #2;
        reset = 1'b1;
        clear_model();
        #1;
        check("async_clear", out, 16'h0000);
        load = 1'b1;
        in   = 16'h7777;
        repeat (2) @(posedge clk);
        #1;
        sweep("reset_hold");
        @(negedge clk);
        reset   = 1'b0;
        address = 6'd21;
        in      = 16'h7777;
        load    = 1'b1;
        @(posedge clk);
        model[21] = 16'h7777;
        #1;
        load = 1'b0;
        check("post_reset_wr", out, 16'h7777);
        sweep("final_sweep");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
